alu: RTL and testbench

//   16-bit combinational ALU for the CPU execute stage: add, subtract, AND, OR, NOR
//   and three shifts, producing N/Z/C/V status flags alongside the result.
//   A clocked status register captures the flags on request for later branch decisions.

---
 rtl/alu.sv | 60 ++++++
 tb/tb_alu.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu.sv
// alu: 16-bit combinational ALU with N/Z/C/V flags and a clocked flag register
module alu (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] A,
    input  logic [15:0] B,
    input  logic [2:0]  fun,
    output logic [15:0] R,
    output logic        N,
    output logic        Z,
    output logic        C,
    output logic        V,
    input  logic        flag_we,
    output logic [3:0]  flags_q
);
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_NOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;

    logic [16:0] addFull;
    logic [16:0] subFull;
    logic [3:0]  shAmt;

    // Both arithmetic paths share one idiom: subtraction adds ~B+1 so bit 16 is the not-borrow carry
    always_comb begin
        addFull = {1'b0, A} + {1'b0, B};
        subFull = {1'b0, A} + {1'b0, ~B} + 17'd1;
        shAmt   = B[3:0];
    end

    // Result mux and flag generation; every opcode is decoded so R is never X
    always_comb begin
        R = (fun == OP_ADD) ? addFull[15:0] :
            (fun == OP_SUB) ? subFull[15:0] :
            (fun == OP_AND) ? (A & B) :
            (fun == OP_OR)  ? (A | B) :
            (fun == OP_NOR) ? ~(A | B) :
            (fun == OP_SHL) ? (A << shAmt) :
            (fun == OP_SHR) ? (A >> shAmt) :
                              16'($signed(A) >>> shAmt);
        N = R[15];
        Z = (R == 16'd0);
        C = (fun == OP_ADD) ? addFull[16] :
            (fun == OP_SUB) ? subFull[16] : 1'b0;
        V = (fun == OP_ADD) ? ((A[15] == B[15]) && (R[15] != A[15])) :
            (fun == OP_SUB) ? ((A[15] != B[15]) && (R[15] != A[15])) : 1'b0;
    end

    // Status register: async clear, captures live flags when flag_we is set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            flags_q <= 4'b0000;
        else if (flag_we)
            flags_q <= {N, Z, C, V};
    end
endmodule

// File: tb/tb_alu.sv
// tb_alu: randomized and directed checks of alu against an arithmetic reference model
module tb_alu;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] A = 16'd0;
    logic [15:0] B = 16'd0;
    logic [2:0]  fun = 3'd0;
    logic        flag_we = 1'b0;
    logic [15:0] R;
    logic        N, Z, C, V;
    logic [3:0]  flags_q;
    int          tests = 0;
    int          fails = 0;

    alu dut (
        .clk(clk), .rst_n(rst_n), .A(A), .B(B), .fun(fun),
        .R(R), .N(N), .Z(Z), .C(C), .V(V),
        .flag_we(flag_we), .flags_q(flags_q)
    );

    always #5 clk = ~clk;

    // Reference: integer arithmetic on unsigned and signed views of the operands
    function automatic logic [19:0] model(input logic [15:0] a, input logic [15:0] b, input logic [2:0] f);
        int ua = int'(a);
        int ub = int'(b);
        int sa = int'($signed(a));
        int sb = int'($signed(b));
        int n = ub % 16;
        int full;
        int sres;
        logic [15:0] r;
        logic c = 1'b0;
        logic v = 1'b0;
        r = 16'd0;
        case (f)
            3'd0: begin
                full = ua + ub; r = full[15:0]; c = (full > 65535);
                sres = sa + sb; v = (sres > 32767) || (sres < -32768);
            end
            3'd1: begin
                full = ua - ub; r = full[15:0]; c = (ua >= ub);
                sres = sa - sb; v = (sres > 32767) || (sres < -32768);
            end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = ~(a | b);
            3'd5: begin full = ua * (1 << n); r = full[15:0]; end
            3'd6: begin full = ua / (1 << n); r = full[15:0]; end
            default: begin sres = sa >>> n; r = sres[15:0]; end
        endcase
        return {r, r[15], r == 16'd0, c, v};
    endfunction

    task automatic apply(input logic [15:0] a, input logic [15:0] b, input logic [2:0] f);
        A = a; B = b; fun = f;
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #1;
        tests++;
        if (flags_q !== 4'b0000) begin
            fails++;
            $display("FAIL reset_async flags_q=%b expected=0000", flags_q);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_add;
        logic [15:0] av [3] = '{16'h0001, 16'hFFFF, 16'h7FFF};
        logic [15:0] bv [3] = '{16'h0001, 16'h0001, 16'h0001};
        logic [19:0] ev [3] = '{{16'h0002, 4'b0000}, {16'h0000, 4'b0110}, {16'h8000, 4'b1001}};
        for (int i = 0; i < 3; i++) begin
            apply(av[i], bv[i], 3'd0);
            tests++;
            if ({R, N, Z, C, V} !== ev[i]) begin
                fails++;
                $display("FAIL add%0d got R=%h NZCV=%b%b%b%b expected %h/%b", i, R, N, Z, C, V, ev[i][19:4], ev[i][3:0]);
            end
        end
    endtask

    task automatic test_sub;
        logic [15:0] av [3] = '{16'h0003, 16'h0000, 16'h8000};
        logic [15:0] bv [3] = '{16'h0007, 16'h0001, 16'h7FFF};
        logic [19:0] ev [3] = '{{16'hFFFC, 4'b1000}, {16'hFFFF, 4'b1000}, {16'h0001, 4'b0011}};
        for (int i = 0; i < 3; i++) begin
            apply(av[i], bv[i], 3'd1);
            tests++;
            if ({R, N, Z, C, V} !== ev[i]) begin
                fails++;
                $display("FAIL sub%0d got R=%h NZCV=%b%b%b%b expected %h/%b", i, R, N, Z, C, V, ev[i][19:4], ev[i][3:0]);
            end
        end
    endtask

    task automatic test_logic;
        logic [2:0]  fv [3] = '{3'd2, 3'd3, 3'd4};
        logic [19:0] ev [3] = '{{16'h000F, 4'b0000}, {16'h0FFF, 4'b0000}, {16'hF000, 4'b1000}};
        for (int i = 0; i < 3; i++) begin
            apply(16'h00FF, 16'h0F0F, fv[i]);
            tests++;
            if ({R, N, Z, C, V} !== ev[i]) begin
                fails++;
                $display("FAIL logic_fun%0d got R=%h NZCV=%b%b%b%b expected %h/%b", fv[i], R, N, Z, C, V, ev[i][19:4], ev[i][3:0]);
            end
        end
    endtask

    task automatic test_shift;
        logic [15:0] av [5] = '{16'h0001, 16'h8000, 16'h8000, 16'h0001, 16'hA5C3};
        logic [15:0] bv [5] = '{16'h0004, 16'h0001, 16'h0001, 16'h0014, 16'hFFF0};
        logic [2:0]  fv [5] = '{3'd5, 3'd6, 3'd7, 3'd5, 3'd7};
        logic [19:0] ev [5] = '{{16'h0010, 4'b0000}, {16'h4000, 4'b0000}, {16'hC000, 4'b1000},
                                {16'h0010, 4'b0000}, {16'hA5C3, 4'b1000}};
        for (int i = 0; i < 5; i++) begin
            apply(av[i], bv[i], fv[i]);
            tests++;
            if ({R, N, Z, C, V} !== ev[i]) begin
                fails++;
                $display("FAIL shift%0d got R=%h NZCV=%b%b%b%b expected %h/%b", i, R, N, Z, C, V, ev[i][19:4], ev[i][3:0]);
            end
        end
    endtask

    task automatic test_random;
        logic [15:0] a, b;
        logic [2:0]  f;
        logic [19:0] e;
        for (int i = 0; i < 400; i++) begin
            a = 16'($urandom);
            b = (i % 4 == 0) ? 16'($urandom_range(0, 3)) : 16'($urandom);
            if (i % 8 == 1) a = {a[15], 15'h7FFF};
            f = 3'($urandom_range(0, 7));
            apply(a, b, f);
            e = model(a, b, f);
            tests++;
            if ({R, N, Z, C, V} !== e) begin
                fails++;
                $display("FAIL rand fun=%0d A=%h B=%h got R=%h NZCV=%b%b%b%b expected %h/%b", f, a, b, R, N, Z, C, V, e[19:4], e[3:0]);
            end
        end
    endtask

    task automatic test_flags;
        @(negedge clk);
        apply(16'hFFFF, 16'h0001, 3'd0);
        flag_we = 1'b1;
        @(posedge clk);
        #1;
        tests++;
        if (flags_q !== 4'b0110) begin
            fails++;
            $display("FAIL flag_load flags_q=%b expected=0110", flags_q);
        end
        @(negedge clk);
        flag_we = 1'b0;
        apply(16'h7FFF, 16'h0001, 3'd0);
        @(posedge clk);
        #1;
        tests++;
        if (flags_q !== 4'b0110) begin
            fails++;
            $display("FAIL flag_hold flags_q=%b expected=0110", flags_q);
        end
        @(negedge clk);
        flag_we = 1'b1;
        @(posedge clk);
        #1;
        tests++;
        if (flags_q !== 4'b1001) begin
            fails++;
            $display("FAIL flag_reload flags_q=%b expected=1001", flags_q);
        end
    endtask

    task automatic test_midop_reset;
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if (flags_q !== 4'b0000) begin
            fails++;
            $display("FAIL midop_reset flags_q=%b expected=0000", flags_q);
        end
        @(posedge clk);
        #1;
        tests++;
        if (flags_q !== 4'b0000) begin
            fails++;
            $display("FAIL reset_beats_we flags_q=%b expected=0000", flags_q);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        tests++;
        if (flags_q !== 4'b0000) begin
            fails++;
            $display("FAIL release_hold flags_q=%b expected=0000", flags_q);
        end
        @(posedge clk);
        #1;
        tests++;
        if (flags_q !== 4'b1001) begin
            fails++;
            $display("FAIL post_release_load flags_q=%b expected=1001", flags_q);
        end
        flag_we = 1'b0;
    endtask

    initial begin
        test_reset;
        test_add;
        test_sub;
        test_logic;
        test_shift;
        test_random;
        test_flags;
        test_midop_reset;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
